// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/exec/mem/wb control sequencer
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   mem_req/mem_we/mem_addr        memory request port (held until mem_ack)
//   mem_ack/mem_rdata              access completion and read data
//   ir, opcode                     instruction register, opcode to decode ROM
//   dec_*                          decoded strobes, sampled at end of DECODE
//   alu_zero, data_addr, target    datapath results, sampled at end of EXEC
//   pc, mdr                        program counter, latched load data
//   rf_we, rf_wsel                 register-file write strobe and source select
//   retire, halted, bus_err        completion pulse and stop flags
module cpu_sequencer #(
   parameter int unsigned     AW           = 16,
   parameter int unsigned     DW           = 16,
   parameter logic [AW-1:0]   RESET_PC     = '0,
   parameter int unsigned     WAIT_TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata,
   output logic [DW-1:0] ir,
   output logic [3:0]    opcode,
   input  logic          dec_mem_rd,
   input  logic          dec_mem_wr,
   input  logic          dec_jump,
   input  logic          dec_branch,
   input  logic          dec_link,
   input  logic          dec_wb,
   input  logic          alu_zero,
   input  logic [AW-1:0] data_addr,
   input  logic [AW-1:0] target,
   output logic [AW-1:0] pc,
   output logic [DW-1:0] mdr,
   output logic          rf_we,
   output logic [1:0]    rf_wsel,
   output logic          retire,
   output logic          halted,
   output logic          bus_err
);

   localparam int unsigned CW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t          state_q;
   logic [AW-1:0]   pc_q, pc_d, mem_addr_q, tgt_q;
   logic [DW-1:0]   ir_q, mdr_q;
   logic [CW-1:0]   wait_q;
   logic            mem_req_q, mem_we_q;
   logic            rd_q, wr_q, jmp_q, br_q, lnk_q, wb_q, take_q;
   logic            rf_we_q, rf_we_d, retire_q, halted_q, bus_err_q;
   logic [1:0]      rf_wsel_q, rf_wsel_d;
   logic            timeout;

   always_comb begin
      pc_d      = take_q ? tgt_q : pc_q + AW'(1);
      rf_we_d   = wb_q | lnk_q | rd_q;
      rf_wsel_d = lnk_q ? 2'd2 : (rd_q ? 2'd1 : 2'd0);
      // The limit cycle itself is the last one allowed to ack.
      timeout   = (WAIT_TIMEOUT != 0) && !mem_ack && (wait_q == CW'(WAIT_TIMEOUT - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         pc_q       <= RESET_PC;
         mem_addr_q <= RESET_PC;
         tgt_q      <= '0;
         ir_q       <= '0;
         mdr_q      <= '0;
         wait_q     <= '0;
         mem_req_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         jmp_q      <= 1'b0;
         br_q       <= 1'b0;
         lnk_q      <= 1'b0;
         wb_q       <= 1'b0;
         take_q     <= 1'b0;
         rf_we_q    <= 1'b0;
         rf_wsel_q  <= 2'd0;
         retire_q   <= 1'b0;
         halted_q   <= 1'b0;
         bus_err_q  <= 1'b0;
      end else begin
         rf_we_q  <= 1'b0;
         retire_q <= 1'b0;
         case (state_q)
            S_FETCH: begin
               // Only the first cycle after reset arrives here with mem_req low.
               if (!mem_req_q) begin
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= 1'b0;
                  mem_addr_q <= pc_q;
                  wait_q     <= '0;
               end else if (mem_ack) begin
                  ir_q      <= mem_rdata;
                  mem_req_q <= 1'b0;
                  state_q   <= S_DECODE;
               end else if (timeout) begin
                  mem_req_q <= 1'b0;
                  bus_err_q <= 1'b1;
                  halted_q  <= 1'b1;
                  state_q   <= S_HALT;
               end else begin
                  wait_q <= wait_q + CW'(1);
               end
            end
            S_DECODE: begin
               if (ir_q[DW-1 -: 4] == 4'hB) begin
                  halted_q <= 1'b1;
                  state_q  <= S_HALT;
               end else begin
                  // A store wins over a load when both are decoded.
                  rd_q    <= dec_mem_rd & ~dec_mem_wr;
                  wr_q    <= dec_mem_wr;
                  jmp_q   <= dec_jump;
                  br_q    <= dec_branch;
                  lnk_q   <= dec_link;
                  wb_q    <= dec_wb;
                  state_q <= S_EXEC;
               end
            end
            S_EXEC: begin
               take_q <= jmp_q | (br_q & alu_zero);
               tgt_q  <= target;
               if (rd_q | wr_q) begin
                  mem_req_q  <= 1'b1;
                  mem_we_q   <= wr_q;
                  mem_addr_q <= data_addr;
                  wait_q     <= '0;
                  state_q    <= S_MEM;
               end else begin
                  rf_we_q   <= rf_we_d;
                  rf_wsel_q <= rf_wsel_d;
                  retire_q  <= 1'b1;
                  state_q   <= S_WB;
               end
            end
            S_MEM: begin
               if (mem_ack) begin
                  if (rd_q) mdr_q <= mem_rdata;
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  rf_we_q   <= rf_we_d;
                  rf_wsel_q <= rf_wsel_d;
                  retire_q  <= 1'b1;
                  state_q   <= S_WB;
               end else if (timeout) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  bus_err_q <= 1'b1;
                  halted_q  <= 1'b1;
                  state_q   <= S_HALT;
               end else begin
                  wait_q <= wait_q + CW'(1);
               end
            end
            S_WB: begin
               pc_q       <= pc_d;
               mem_req_q  <= 1'b1;
               mem_we_q   <= 1'b0;
               mem_addr_q <= pc_d;
               wait_q     <= '0;
               state_q    <= S_FETCH;
            end
            S_HALT: begin
            end
            default: state_q <= S_HALT;
         endcase
      end
   end

   assign mem_req  = mem_req_q;
   assign mem_we   = mem_we_q;
   assign mem_addr = mem_addr_q;
   assign ir       = ir_q;
   assign opcode   = ir_q[DW-1 -: 4];
   assign pc       = pc_q;
   assign mdr      = mdr_q;
   assign rf_we    = rf_we_q;
   assign rf_wsel  = rf_wsel_q;
   assign retire   = retire_q;
   assign halted   = halted_q;
   assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req, mem_we, mem_ack;
   logic [15:0] mem_addr, mem_rdata, ir, data_addr, target, pc, mdr;
   logic [3:0]  opcode;
   logic        dec_mem_rd, dec_mem_wr, dec_jump, dec_branch, dec_link, dec_wb;
   logic        alu_zero, rf_we, retire, halted, bus_err;
   logic [1:0]  rf_wsel;

   int          n_chk = 0;
   int          n_fail = 0;
   logic [15:0] m_pc = 16'h0100;
   logic [15:0] m_mdr = 16'h0000;

   always #5 clk = ~clk;

   cpu_sequencer #(.AW(16), .DW(16), .RESET_PC(16'h0100), .WAIT_TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .ir(ir), .opcode(opcode),
      .dec_mem_rd(dec_mem_rd), .dec_mem_wr(dec_mem_wr), .dec_jump(dec_jump),
      .dec_branch(dec_branch), .dec_link(dec_link), .dec_wb(dec_wb),
      .alu_zero(alu_zero), .data_addr(data_addr), .target(target),
      .pc(pc), .mdr(mdr), .rf_we(rf_we), .rf_wsel(rf_wsel),
      .retire(retire), .halted(halted), .bus_err(bus_err)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_req();
      int n = 0;
      while (mem_req !== 1'b1 && n < 10) begin
         mem_ack   = 1'($urandom_range(0, 1));
         mem_rdata = 16'($urandom);
         @(negedge clk);
         n++;
      end
      chk("req_start", {31'd0, mem_req}, 32'd1);
   endtask

   // dec = {rd, wr, jump, branch, link, wb}; fw/mw = wait cycles on fetch/data access
   task automatic run_instr(input logic [15:0] instr, input logic [5:0] dec, input logic zero,
                            input logic [15:0] daddr, input logic [15:0] tgt,
                            input logic [15:0] ldata, input int fw, input int mw);
      logic        is_mem = dec[5] | dec[4];
      logic        is_ld  = dec[5] & ~dec[4];
      int          exp_lat = 4 + fw + (is_mem ? 1 + mw : 0);
      logic [15:0] exp_pc = (dec[3] || (dec[2] && zero)) ? tgt : m_pc + 16'd1;
      logic        exp_we = dec[1] | dec[0] | is_ld;
      logic [1:0]  exp_sel = dec[1] ? 2'd2 : (is_ld ? 2'd1 : 2'd0);
      int          acc = 0, wcnt = 0, cyc = 0, ret_cyc = 0;
      logic        done = 1'b0;
      logic        ack;
      {dec_mem_rd, dec_mem_wr, dec_jump, dec_branch, dec_link, dec_wb} = dec;
      alu_zero = zero; data_addr = daddr; target = tgt;
      wait_req();
      while (!done && cyc < 40) begin
         cyc++;
         if (mem_req) begin
            if (wcnt == 0) begin
               chk(acc == 0 ? "fetch_addr" : "data_addr", {16'd0, mem_addr}, {16'd0, acc == 0 ? m_pc : daddr});
               chk(acc == 0 ? "fetch_we" : "data_we", {31'd0, mem_we}, {31'd0, acc == 0 ? 1'b0 : dec[4]});
            end
            ack       = (wcnt == (acc == 0 ? fw : mw));
            mem_ack   = ack;
            mem_rdata = ack ? (acc == 0 ? instr : ldata) : 16'($urandom);
            if (ack) begin acc++; wcnt = 0; end else wcnt++;
         end else begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = 16'($urandom);
         end
         if (retire) begin
            ret_cyc = cyc;
            done    = 1'b1;
            chk("ir", {16'd0, ir}, {16'd0, instr});
            chk("rf_we", {31'd0, rf_we}, {31'd0, exp_we});
            chk("rf_wsel", {30'd0, rf_wsel}, {30'd0, exp_sel});
         end
         @(negedge clk);
      end
      mem_ack = 1'b0;
      if (is_ld) m_mdr = ldata;
      chk("latency", ret_cyc, exp_lat);
      chk("next_pc", {16'd0, pc}, {16'd0, exp_pc});
      chk("mdr", {16'd0, mdr}, {16'd0, m_mdr});
      chk("retire_pulse", {30'd0, retire, mem_req}, 32'd1);
      m_pc = exp_pc;
   endtask

   initial begin
      mem_ack = 1'b0; mem_rdata = '0; alu_zero = 1'b0; data_addr = '0; target = '0;
      {dec_mem_rd, dec_mem_wr, dec_jump, dec_branch, dec_link, dec_wb} = '0;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_pc", {16'd0, pc}, 32'h0100);
      chk("rst_flags", {26'd0, mem_req, rf_we, retire, halted, bus_err, mem_we}, 32'd0);
      chk("rst_regs", {ir, mdr}, 32'd0);
      rst_n = 1'b1;

      // reset pulse while a fetch is outstanding
      wait_req();
      chk("first_fetch_addr", {16'd0, mem_addr}, 32'h0100);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_fetch_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mid_fetch_pc", {16'd0, pc}, 32'h0100);
      @(negedge clk);
      rst_n = 1'b1;

      // directed instructions
      run_instr(16'h0123, 6'b000001, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 0);  // ALU
      run_instr(16'h1234, 6'b100000, 1'b0, 16'h2000, 16'h0000, 16'hBEEF, 0, 2);  // load, 2 waits
      run_instr(16'h2000, 6'b000100, 1'b1, 16'h0000, 16'h0040, 16'h0000, 0, 0);  // branch taken
      run_instr(16'h2001, 6'b000100, 1'b0, 16'h0000, 16'h0040, 16'h0000, 3, 0);  // not taken, ack at limit
      run_instr(16'h2002, 6'b001100, 1'b0, 16'h0000, 16'h0040, 16'h0000, 0, 0);  // jump beats branch
      run_instr(16'h3000, 6'b110001, 1'b0, 16'h3333, 16'h0000, 16'h5555, 0, 1);  // rd+wr = store
      run_instr(16'h4000, 6'b001000, 1'b0, 16'h0000, 16'hFFFF, 16'h0000, 1, 0);  // jump to FFFF
      run_instr(16'h5000, 6'b000010, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0, 0);  // link, wrap to 0
      run_instr(16'h6000, 6'b100010, 1'b0, 16'h0800, 16'h0000, 16'hA5A5, 0, 3);  // link beats load

      // randomized instructions against the model
      for (int i = 0; i < 40; i++) begin
         logic [15:0] ins = 16'($urandom);
         if (ins[15:12] == 4'hB) ins[15:12] = 4'h3;
         run_instr(ins, 6'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
                   16'($urandom), 16'($urandom), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)));
      end

      // halt instruction
      wait_req();
      mem_ack = 1'b1; mem_rdata = 16'hB5A5;
      @(negedge clk);
      mem_ack = 1'b0;
      chk("halt_in_decode", {31'd0, halted}, 32'd0);
      @(negedge clk);
      chk("halted", {31'd0, halted}, 32'd1);
      for (int i = 0; i < 12; i++) begin
         mem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("halt_quiet", {13'd0, mem_req, retire, rf_we, pc}, {16'd0, m_pc});
      end

      // fetch timeout
      mem_ack = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_pc = 16'h0100;
      wait_req();
      for (int i = 0; i < 4; i++) begin
         mem_ack = 1'b0;
         chk("to_waiting", {30'd0, mem_req, bus_err}, 32'd2);
         @(negedge clk);
      end
      chk("to_tripped", {29'd0, mem_req, bus_err, halted}, 32'd3);
      for (int i = 0; i < 4; i++) begin
         mem_ack = 1'($urandom_range(0, 1));
         @(negedge clk);
         chk("to_stays_halted", {29'd0, mem_req, bus_err, halted}, 32'd3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
